// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM: register offsets, bit indices, channel states.
package pwm_pkg;

  localparam int unsigned OFF_CTRL  = 0;
  localparam int unsigned OFF_CHSEL = 1;
  localparam int unsigned OFF_LOW   = 2;

  localparam int unsigned CTRL_SOFT_RST = 0;
  localparam int unsigned CTRL_GEN_EN   = 1;

  localparam int unsigned MODE_EN    = 0;
  localparam int unsigned MODE_BURST = 1;
  localparam int unsigned MODE_POL   = 2;
  localparam int unsigned MODE_W     = 3;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_DONE = 1;

  typedef logic [1:0] ch_state_t;
  localparam ch_state_t CH_IDLE = 2'd0;
  localparam ch_state_t CH_LOW  = 2'd1;
  localparam ch_state_t CH_HIGH = 2'd2;

  // Window layout past LOW depends on the counter byte count.
  function automatic int unsigned off_high(input int unsigned bytes);
    return OFF_LOW + bytes;
  endfunction

  function automatic int unsigned off_mode(input int unsigned bytes);
    return OFF_LOW + 2 * bytes;
  endfunction

  function automatic int unsigned off_burst(input int unsigned bytes);
    return OFF_LOW + 2 * bytes + 1;
  endfunction

  function automatic int unsigned off_status(input int unsigned bytes);
    return OFF_LOW + 2 * bytes + 2;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM generator: shadow/active LOW and HIGH counts, burst counting, registered out/busy.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       clr,
  input  logic       gen_en,
  input  logic       wr,
  input  logic [7:0] wr_off,
  input  logic [7:0] wr_data,
  input  logic [7:0] rd_off,
  output logic [7:0] rd_data_c,
  output logic       out,
  output logic       busy
);

  localparam int unsigned BYTES = CNT_W / 8;
  localparam logic [7:0] OFF_H     = 8'(off_high(BYTES));
  localparam logic [7:0] OFF_MODE  = 8'(off_mode(BYTES));
  localparam logic [7:0] OFF_BURST = 8'(off_burst(BYTES));
  localparam logic [7:0] OFF_STAT  = 8'(off_status(BYTES));
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  ch_state_t         state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [CNT_W-1:0]  act_low, act_low_nxt, act_high, act_high_nxt;
  logic [CNT_W-1:0]  sh_low, sh_low_nxt, sh_high, sh_high_nxt;
  logic [MODE_W-1:0] mode, mode_nxt;
  logic [7:0]        burst, burst_nxt, bcnt, bcnt_nxt;
  logic              done, done_nxt, out_nxt, busy_nxt;
  logic              period_end;
  logic              run;
  logic [7:0]        burst_tgt;

  assign run       = gen_en & mode[MODE_EN];
  assign burst_tgt = (burst == 8'd0) ? 8'd1 : burst;

  // Next-state: register writes, then the period FSM, then stop/clear overrides.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    act_low_nxt  = act_low;
    act_high_nxt = act_high;
    sh_low_nxt   = sh_low;
    sh_high_nxt  = sh_high;
    mode_nxt     = mode;
    burst_nxt    = burst;
    bcnt_nxt     = bcnt;
    done_nxt     = done;
    period_end   = 1'b0;

    if (wr) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (wr_off == 8'(OFF_LOW + b)) sh_low_nxt[8*b +: 8] = wr_data;
        if (wr_off == OFF_H + 8'(b))   sh_high_nxt[8*b +: 8] = wr_data;
      end
      if (wr_off == OFF_MODE) begin
        mode_nxt = wr_data[MODE_W-1:0];
        if (wr_data[MODE_EN] && !mode[MODE_EN]) done_nxt = 1'b0;
      end
      if (wr_off == OFF_BURST) burst_nxt = wr_data;
    end

    case (state)
      CH_IDLE: begin
        if (run && (sh_low != '0 || sh_high != '0)) begin
          act_low_nxt  = sh_low;
          act_high_nxt = sh_high;
          cnt_nxt      = '0;
          state_nxt    = (sh_low != '0) ? CH_LOW : CH_HIGH;
        end
      end
      CH_LOW: begin
        if (cnt == act_low - ONE) begin
          cnt_nxt = '0;
          if (act_high != '0) state_nxt = CH_HIGH;
          else                period_end = 1'b1;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      CH_HIGH: begin
        if (cnt == act_high - ONE) period_end = 1'b1;
        else                       cnt_nxt = cnt + ONE;
      end
      default: state_nxt = CH_IDLE;
    endcase

    // Period boundary is the only point where new LOW/HIGH values take hold.
    if (period_end) begin
      act_low_nxt  = sh_low;
      act_high_nxt = sh_high;
      cnt_nxt      = '0;
      if (mode[MODE_BURST]) bcnt_nxt = bcnt + 8'd1;
      if (mode[MODE_BURST] && bcnt_nxt >= burst_tgt) begin
        state_nxt          = CH_IDLE;
        done_nxt           = 1'b1;
        mode_nxt[MODE_EN]  = 1'b0;
      end else if (sh_low != '0) begin
        state_nxt = CH_LOW;
      end else if (sh_high != '0) begin
        state_nxt = CH_HIGH;
      end else begin
        state_nxt = CH_IDLE;
      end
    end

    if (state != CH_IDLE && !run) begin
      state_nxt = CH_IDLE;
      cnt_nxt   = '0;
    end
    if (state_nxt == CH_IDLE) bcnt_nxt = '0;

    if (clr) begin
      state_nxt    = CH_IDLE;
      cnt_nxt      = '0;
      act_low_nxt  = '0;
      act_high_nxt = '0;
      sh_low_nxt   = '0;
      sh_high_nxt  = '0;
      mode_nxt     = '0;
      burst_nxt    = '0;
      bcnt_nxt     = '0;
      done_nxt     = 1'b0;
    end

    out_nxt  = (state_nxt == CH_HIGH) ^ mode_nxt[MODE_POL];
    busy_nxt = (state_nxt != CH_IDLE);
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state    <= CH_IDLE;
      cnt      <= '0;
      act_low  <= '0;
      act_high <= '0;
      sh_low   <= '0;
      sh_high  <= '0;
      mode     <= '0;
      burst    <= '0;
      bcnt     <= '0;
      done     <= 1'b0;
      out      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      act_low  <= act_low_nxt;
      act_high <= act_high_nxt;
      sh_low   <= sh_low_nxt;
      sh_high  <= sh_high_nxt;
      mode     <= mode_nxt;
      burst    <= burst_nxt;
      bcnt     <= bcnt_nxt;
      done     <= done_nxt;
      out      <= out_nxt;
      busy     <= busy_nxt;
    end
  end

  // Readback reflects the shadow values, which is what software last wrote.
  always_comb begin
    rd_data_c = '0;
    for (int unsigned b = 0; b < BYTES; b++) begin
      if (rd_off == 8'(OFF_LOW + b)) rd_data_c = sh_low[8*b +: 8];
      if (rd_off == OFF_H + 8'(b))   rd_data_c = sh_high[8*b +: 8];
    end
    if (rd_off == OFF_MODE)  rd_data_c = 8'(mode);
    if (rd_off == OFF_BURST) rd_data_c = burst;
    if (rd_off == OFF_STAT) begin
      rd_data_c[STAT_BUSY] = busy;
      rd_data_c[STAT_DONE] = done;
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM top: register window decode, CTRL/CHSEL, read mux and channel write steering.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_W     = 32,
  parameter logic [7:0]  BASE_ADDR = 8'h36
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic [7:0]        addr,
  input  logic [7:0]        data_in,
  input  logic              we,
  output logic [7:0]        data_out,
  output logic [NUM_CH-1:0] out,
  output logic [NUM_CH-1:0] busy
);

  localparam int unsigned BYTES    = CNT_W / 8;
  localparam logic [7:0]  OFF_STAT = 8'(off_status(BYTES));

  logic [7:0]        off_c;
  logic              in_win_c, ctrl_wr_c, soft_rst_c;
  logic              soft_rst, soft_rst_nxt;
  logic              gen_en, gen_en_nxt;
  logic [3:0]        chsel, chsel_nxt;
  logic [7:0]        data_out_nxt;
  logic [NUM_CH-1:0] ch_wr;
  logic [7:0]        ch_rdata [NUM_CH];

  assign off_c      = addr - BASE_ADDR;
  assign in_win_c   = (off_c <= OFF_STAT);
  assign ctrl_wr_c  = we && in_win_c && (off_c == 8'(OFF_CTRL));
  // A pending soft reset clears everything and swallows any write in the same cycle.
  assign soft_rst_c = soft_rst || (ctrl_wr_c && data_in[CTRL_SOFT_RST]);

  always_comb begin
    soft_rst_nxt = ctrl_wr_c && data_in[CTRL_SOFT_RST] && !soft_rst;
    gen_en_nxt   = gen_en;
    chsel_nxt    = chsel;
    data_out_nxt = '0;
    ch_wr        = '0;

    if (we && in_win_c && !soft_rst_c) begin
      if (off_c == 8'(OFF_CTRL))  gen_en_nxt = data_in[CTRL_GEN_EN];
      if (off_c == 8'(OFF_CHSEL)) chsel_nxt  = data_in[3:0];
      for (int i = 0; i < NUM_CH; i++) begin
        if (off_c >= 8'(OFF_LOW) && chsel == 4'(i)) ch_wr[i] = 1'b1;
      end
    end

    if (in_win_c) begin
      if (off_c == 8'(OFF_CTRL)) begin
        data_out_nxt[CTRL_SOFT_RST] = soft_rst;
        data_out_nxt[CTRL_GEN_EN]   = gen_en;
      end else if (off_c == 8'(OFF_CHSEL)) begin
        data_out_nxt = {4'b0, chsel};
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (chsel == 4'(i)) data_out_nxt = ch_rdata[i];
        end
      end
    end

    if (soft_rst_c) begin
      gen_en_nxt   = 1'b0;
      chsel_nxt    = '0;
      data_out_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      soft_rst <= 1'b0;
      gen_en   <= 1'b0;
      chsel    <= '0;
      data_out <= '0;
    end else begin
      soft_rst <= soft_rst_nxt;
      gen_en   <= gen_en_nxt;
      chsel    <= chsel_nxt;
      data_out <= data_out_nxt;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk       (clk),
      .res_n     (res_n),
      .clr       (soft_rst_c),
      .gen_en    (gen_en),
      .wr        (ch_wr[i]),
      .wr_off    (off_c),
      .wr_data   (data_in),
      .rd_off    (off_c),
      .rd_data_c (ch_rdata[i]),
      .out       (out[i]),
      .busy      (busy[i])
    );
  end

endmodule
